control_unit: RTL and testbench
===============================

# control_unit

Sequencing core of the 16-bit accumulator CPU. Decodes one instruction at a time and holds architectural registers X, Y and ACC. Drives the ALU, the stack unit and the data-memory strobes. Computes the next PC from the ALU flags and presents it to the external PC register.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- rst_b  in  1  asynchronous, active-low reset
- fl_zero / fl_negative / fl_carry / fl_overflow  in  1 each  ALU status flags, sampled in EXEC
- instruction  in  16  current instruction word; must be stable while pc_out == pc
- imm  in  16  operand bus: immediate word (MOVI, ALU-imm); memory read data for LOAD, valid in WAIT
- pc  in  10  current PC value from the external PC register
- pop_out  in  16  stack read data, valid with pop_done
- pop_done / push_done  in  1  stack handshake completion pulses
- alu_out  in  16  ALU result, valid with alu_done
- alu_done  in  1  ALU completion pulse
- opcode  out  6  latched instruction[15:10], forwarded to the ALU
- pc_out  out  10  next PC; the external PC register loads it every cycle
- register_write_enable  out  1  one-cycle pulse when X, Y or ACC is written
- address  out  16  data-memory address, {8'b0, instruction[7:0]}
- push_data  out  16  outgoing data word for STORE and PUSH
- write_enable  out  16  strobe vector: bit0 memory write, bit1 stack push; other bits 0
- read_enable  out  16  strobe vector: bit0 memory read, bit1 stack pop; other bits 0
- term1 / term2  out  16  ALU operands
- alu_enable  out  1  one-cycle ALU start pulse
- branch  out  1  one-cycle pulse in WB when a branch is taken

## Operation
- Instruction fields:
  - [15:10] opcode.
  - [9:8] register select: 00 = X, 01 = Y, 1x = ACC.
  - [7:0] memory address.
  - [9:0] branch target.
- Opcode map:
  - 00 NOP.
  - 01 LOAD: reg <= imm after memory read.
  - 02 STORE: mem[addr] <= reg.
  - 03 MOVI: reg <= imm.
  - 04 PUSH: push reg.
  - 05 POP: reg <= pop_out.
  - 08 BRA: unconditional branch.
  - 09 BRZ / 0A BRN / 0B BRC / 0C BRO: branch if fl_zero / fl_negative / fl_carry / fl_overflow.
  - 10–1F ALU ops:
    - term1 = reg[9:8].
    - term2 = imm if instruction[7] = 1, else reg[6:5].
    - Result is written to ACC, except 1B CMP and 1C TST, which write nothing.
  - All other opcodes execute as NOP.
- State machine:
  - DECODE: latch instruction and opcode → EXEC.
  - EXEC:
    - Assert the relevant strobe for one cycle: alu_enable, read_enable bit, or write_enable bit.
    - Evaluate the branch condition.
    - Go to WAIT for LOAD/ALU/PUSH/POP; otherwise go to WB.
  - WAIT: hold until the done signal.
    - LOAD: exactly one cycle.
    - ALU: alu_done.
    - PUSH: push_done.
    - POP: pop_done.
    - Capture the result, then go to WB.
  - WB:
    - Register write with a register_write_enable pulse.
    - pc_out = taken branch ? target : pc + 1 (10-bit wrap: 1023 → 0).
    - Go to DECODE.
- Outside WB, pc_out = pc.
- push_data and term1/term2 hold from EXEC through WB.
- A done pulse arriving outside WAIT is ignored.
- Flags are sampled in EXEC only. A simultaneous flag change in that cycle uses the value present at the clock edge.

## Timing
- Reset (asynchronous, any state):
  - State → DECODE.
  - X = Y = ACC = 0.
  - Every output = 0, including pc_out = 0.
  - In-flight handshakes are abandoned.
- Latency from DECODE to WB:
  - NOP/STORE/MOVI/branches: 3 cycles.
  - LOAD: 4 cycles.
  - ALU/PUSH/POP: 3 + wait cycles (minimum 4 when done arrives in the first WAIT cycle).
- Strobes are single-cycle registered pulses. No strobe is re-asserted while in WAIT.
- The new PC is visible one cycle after WB. The next DECODE sees the new instruction.

## Configuration
- CONTROL_UNIT_STACK_EN:
  - Defined: PUSH/POP are implemented as above.
  - Undefined:
    - Opcodes 04/05 execute as NOP (3 cycles).
    - write_enable[1] and read_enable[1] are tied to 0.
    - pop_out, pop_done and push_done are ignored.

## Test plan
- Reset mid-WAIT of an ALU op: all outputs 0, X/Y/ACC 0; the next instruction decodes normally after release.
- MOVI X, imm = 16'h1234, then STORE X to addr 8'h10: address = 16'h0010, write_enable = 16'h0001 for one cycle, push_data = 16'h1234, pc_out = pc + 1.
- ALU 10 (ADD) X + imm 16'h0005, alu_done three cycles after alu_enable, alu_out = 16'h1239: ACC = 16'h1239, register_write_enable pulses once, total 6 cycles.
- BRZ target 10'h3FF:
  - fl_zero = 1: branch pulse, pc_out = 10'h3FF.
  - fl_zero = 0 with pc = 10'h3FF: pc_out = 10'h000, no branch pulse.
- PUSH Y = 16'h5678 with push_done after 2 cycles; then POP to X with pop_out = 16'hABCD: X = 16'hABCD; read_enable[1] and write_enable[1] each pulse once.
- Undefined opcode 6'h3F: no strobes, no register write, pc_out = pc + 1 after 3 cycles.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if: bus between control_unit and its ALU, stack unit, data memory and PC register
interface control_unit_if;
  logic        fl_zero, fl_negative, fl_carry, fl_overflow;
  logic [15:0] instruction, imm, pop_out, alu_out;
  logic [9:0]  pc;
  logic        pop_done, push_done, alu_done;
  logic [5:0]  opcode;
  logic [9:0]  pc_out;
  logic        register_write_enable, alu_enable, branch;
  logic [15:0] address, push_data, write_enable, read_enable, term1, term2;
  modport master (
    input  fl_zero, fl_negative, fl_carry, fl_overflow, instruction, imm, pc,
           pop_out, pop_done, push_done, alu_out, alu_done,
    output opcode, pc_out, register_write_enable, address, push_data,
           write_enable, read_enable, term1, term2, alu_enable, branch
  );
  modport slave (
    output fl_zero, fl_negative, fl_carry, fl_overflow, instruction, imm, pc,
           pop_out, pop_done, push_done, alu_out, alu_done,
    input  opcode, pc_out, register_write_enable, address, push_data,
           write_enable, read_enable, term1, term2, alu_enable, branch
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: DECODE/EXEC/WAIT/WB sequencer of the 16-bit accumulator CPU.
// PUSH/POP exist only when CONTROL_UNIT_STACK_EN is defined; otherwise they run as NOP.
module control_unit (
  input logic clk,
  input logic rst_b,
  control_unit_if.master bus
);
  localparam logic [1:0] DECODE = 2'd0, EXEC = 2'd1, WAIT = 2'd2, WB = 2'd3;
`ifdef CONTROL_UNIT_STACK_EN
  localparam logic STACK = 1'b1;
`else
  localparam logic STACK = 1'b0;
`endif
  logic [1:0] state;
  logic [5:0] op, in_op;
  logic [9:0] ir, npc;
  logic [15:0] x, y, acc, res, t1, t2, pd, r_a, r_b;
  logic [1:0] we, re, dsel;
  logic alu_en, rwe, br;
  logic is_load, is_alu, is_push, is_pop, wr_reg, taken, needs_wait, done;
  always_comb begin
    in_op = bus.instruction[15:10];
    r_a = bus.instruction[9] ? acc : bus.instruction[8] ? y : x;
    r_b = bus.instruction[6] ? acc : bus.instruction[5] ? y : x;
    is_load = op == 6'h01;
    is_alu = op[5:4] == 2'b01;
    is_push = STACK && op == 6'h04;
    is_pop = STACK && op == 6'h05;
    taken = (op == 6'h08) || (op == 6'h09 && bus.fl_zero) || (op == 6'h0A && bus.fl_negative)
         || (op == 6'h0B && bus.fl_carry) || (op == 6'h0C && bus.fl_overflow);
    needs_wait = is_load || is_alu || is_push || is_pop;
    done = is_load || (is_alu && bus.alu_done) || (is_push && bus.push_done) || (is_pop && bus.pop_done);
    wr_reg = is_load || op == 6'h03 || is_pop || (is_alu && op != 6'h1B && op != 6'h1C);
    dsel = is_alu ? 2'b10 : ir[9:8];
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= DECODE;
      op <= '0;
      ir <= '0;
      npc <= '0;
      x <= '0;
      y <= '0;
      acc <= '0;
      res <= '0;
      t1 <= '0;
      t2 <= '0;
      pd <= '0;
      we <= '0;
      re <= '0;
      alu_en <= 1'b0;
      rwe <= 1'b0;
      br <= 1'b0;
    end else begin
      case (state)
        DECODE: begin
          op <= in_op;
          ir <= bus.instruction[9:0];
          alu_en <= in_op[5:4] == 2'b01;
          we <= {STACK && in_op == 6'h04, in_op == 6'h02};
          re <= {STACK && in_op == 6'h05, in_op == 6'h01};
          t1 <= r_a;
          t2 <= bus.instruction[7] ? bus.imm : r_b;
          pd <= r_a;
          res <= bus.imm;
          state <= EXEC;
        end
        EXEC: begin
          alu_en <= 1'b0;
          we <= '0;
          re <= '0;
          br <= taken;
          rwe <= wr_reg && !needs_wait;
          npc <= taken ? ir : bus.pc + 10'd1;
          state <= needs_wait ? WAIT : WB;
        end
        WAIT: if (done) begin
          res <= is_alu ? bus.alu_out : is_pop ? bus.pop_out : bus.imm;
          rwe <= wr_reg;
          state <= WB;
        end
        WB: begin
          if (rwe) begin
            if (dsel[1]) acc <= res;
            else if (dsel[0]) y <= res;
            else x <= res;
          end
          rwe <= 1'b0;
          br <= 1'b0;
          state <= DECODE;
        end
      endcase
    end
  // the external PC register reloads pc_out every cycle, so outside WB it must echo pc
  assign bus.pc_out = !rst_b ? '0 : state == WB ? npc : bus.pc;
  assign bus.opcode = op;
  assign bus.register_write_enable = rwe;
  assign bus.address = {8'h00, ir[7:0]};
  assign bus.push_data = pd;
  assign bus.write_enable = {14'h0000, we};
  assign bus.read_enable = {14'h0000, re};
  assign bus.term1 = t1;
  assign bus.term2 = t2;
  assign bus.alu_enable = alu_en;
  assign bus.branch = br;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random instruction stream checked against an instruction-level model
module tb_control_unit;
`ifdef CONTROL_UNIT_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] regs [3];
  logic [9:0] mpc = '0;
  logic [5:0] ops [24] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                           6'h0C, 6'h10, 6'h11, 6'h15, 6'h1A, 6'h1B, 6'h1C, 6'h1F, 6'h06, 6'h07,
                           6'h0D, 6'h20, 6'h3F, 6'h02};
  control_unit_if bus ();
  control_unit dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  // external PC register: loads pc_out on every rising edge
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) bus.pc <= '0;
    else bus.pc <= bus.pc_out;
  function automatic int ri(input logic [1:0] s);
    return s[1] ? 2 : s[0] ? 1 : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".opcode"}, 32'(bus.opcode), 0);
    chk({tag, ".pc_out"}, 32'(bus.pc_out), 0);
    chk({tag, ".rwe"}, 32'(bus.register_write_enable), 0);
    chk({tag, ".address"}, 32'(bus.address), 0);
    chk({tag, ".push_data"}, 32'(bus.push_data), 0);
    chk({tag, ".we"}, 32'(bus.write_enable), 0);
    chk({tag, ".re"}, 32'(bus.read_enable), 0);
    chk({tag, ".term1"}, 32'(bus.term1), 0);
    chk({tag, ".term2"}, 32'(bus.term2), 0);
    chk({tag, ".alu_en"}, 32'(bus.alu_enable), 0);
    chk({tag, ".branch"}, 32'(bus.branch), 0);
  endtask
  // Runs one instruction starting at the falling edge inside its DECODE cycle; ends inside the next DECODE.
  task automatic run(input logic [15:0] ins, input logic [15:0] iv, input logic [15:0] mv,
                     input logic [15:0] rv, input int lat, input logic [3:0] fl, input bit spur);
    logic [5:0] o;
    bit alu, ld, st, mo, ps, pp, wr, tk;
    int len;
    logic [4:0] strobe;
    logic [15:0] a, t2v;
    logic [9:0] npc;
    o = ins[15:10];
    alu = o >= 6'h10 && o <= 6'h1F;
    ld = o == 6'h01;
    st = o == 6'h02;
    mo = o == 6'h03;
    ps = STK && o == 6'h04;
    pp = STK && o == 6'h05;
    tk = (o == 6'h08) || (o >= 6'h09 && o <= 6'h0C && fl[2'(o - 6'h09)]);
    len = ld ? 4 : (alu || ps || pp) ? 3 + lat : 3;
    wr = ld || mo || pp || (alu && o != 6'h1B && o != 6'h1C);
    strobe = {alu, ps, st, pp, ld};
    a = regs[ri(ins[9:8])];
    t2v = ins[7] ? iv : regs[ri(ins[6:5])];
    npc = tk ? ins[9:0] : mpc + 10'd1;
    bus.instruction = ins;
    bus.imm = iv;
    {bus.fl_overflow, bus.fl_carry, bus.fl_negative, bus.fl_zero} = fl;
    for (int k = 1; k <= len; k++) begin
      chk("strobes", 32'({bus.alu_enable, bus.write_enable[1:0], bus.read_enable[1:0]}), k == 2 ? 32'(strobe) : 0);
      chk("strobe_hi", 32'({bus.write_enable[15:2], bus.read_enable[15:2]}), 0);
      chk("rwe", 32'(bus.register_write_enable), 32'(k == len && wr));
      chk("branch", 32'(bus.branch), 32'(k == len && tk));
      chk("pc_out", 32'(bus.pc_out), k == len ? 32'(npc) : 32'(mpc));
      if (k >= 2) begin
        chk("opcode", 32'(bus.opcode), 32'(o));
        chk("address", 32'(bus.address), 32'({8'h00, ins[7:0]}));
        if (alu) begin
          chk("term1", 32'(bus.term1), 32'(a));
          chk("term2", 32'(bus.term2), 32'(t2v));
        end
        if (st || ps) chk("push_data", 32'(bus.push_data), 32'(a));
      end
      bus.imm = (ld && k == 3) ? mv : iv;
      bus.alu_out = (k == 2 + lat) ? rv : ~rv;
      bus.pop_out = (k == 2 + lat) ? rv : ~rv;
      bus.alu_done = (o >= 6'h10 && o <= 6'h1F) && (k == 2 + lat || (k == 2 && spur));
      bus.push_done = o == 6'h04 && (k == 2 + lat || (k == 2 && spur));
      bus.pop_done = o == 6'h05 && (k == 2 + lat || (k == 2 && spur));
      @(posedge clk);
      @(negedge clk);
    end
    bus.alu_done = 1'b0;
    bus.push_done = 1'b0;
    bus.pop_done = 1'b0;
    if (wr) regs[alu ? 2 : ri(ins[9:8])] = (alu || pp) ? rv : ld ? mv : iv;
    mpc = npc;
  endtask
  initial begin
    logic [31:0] r, r2;
    foreach (regs[i]) regs[i] = '0;
    bus.instruction = '0;
    bus.imm = '0;
    bus.pop_out = '0;
    bus.alu_out = '0;
    bus.pop_done = 1'b0;
    bus.push_done = 1'b0;
    bus.alu_done = 1'b0;
    {bus.fl_overflow, bus.fl_carry, bus.fl_negative, bus.fl_zero} = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_b = 1'b1;
    run({6'h03, 2'b00, 8'h00}, 16'h1234, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h02, 2'b00, 8'h10}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h10, 2'b00, 8'h80}, 16'h0005, 16'h0, 16'h1239, 3, 4'h0, 1'b1);
    run({6'h02, 2'b10, 8'h20}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h09, 10'h3FF}, 16'h0, 16'h0, 16'h0, 1, 4'b0001, 1'b0);
    run({6'h09, 10'h3FF}, 16'h0, 16'h0, 16'h0, 1, 4'b1110, 1'b0);
    run({6'h03, 2'b01, 8'h00}, 16'h5678, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h04, 2'b01, 8'h00}, 16'h0000, 16'h0, 16'h0, 2, 4'h0, 1'b0);
    run({6'h05, 2'b00, 8'h00}, 16'h0000, 16'h0, 16'hABCD, 1, 4'h0, 1'b1);
    run({6'h02, 2'b00, 8'h30}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h3F, 10'h155}, 16'hFFFF, 16'h0, 16'h0, 1, 4'hF, 1'b1);
    run({6'h01, 2'b01, 8'h44}, 16'hDEAD, 16'hBEEF, 16'h0, 1, 4'h0, 1'b0);
    run({6'h02, 2'b01, 8'h45}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h1B, 2'b01, 8'h40}, 16'h7777, 16'h0, 16'h0F0F, 1, 4'h0, 1'b0);
    run({6'h02, 2'b10, 8'h46}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      r2 = $urandom();
      run({ops[$urandom_range(0, 23)], r[9:0]}, r[31:16], r2[15:0], r2[31:16],
          int'($urandom_range(1, 4)), r[13:10], r[14]);
    end
    for (int s = 0; s < 3; s++) run({6'h02, 2'(s), 8'h50}, 16'h0, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    // reset while an ALU op is stuck in WAIT
    bus.instruction = {6'h10, 2'b10, 8'h80};
    bus.imm = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 chk_zero("midwait");
    @(negedge clk);
    rst_b = 1'b1;
    foreach (regs[i]) regs[i] = '0;
    mpc = '0;
    for (int s = 0; s < 3; s++) run({6'h02, 2'(s), 8'h60}, 16'h0, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    run({6'h11, 2'b00, 8'h80}, 16'h0042, 16'h0, 16'h2222, 1, 4'h0, 1'b0);
    run({6'h02, 2'b10, 8'h61}, 16'h0000, 16'h0, 16'h0, 1, 4'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
